// File: rtl/sequence_detector.sv
// -----------------------------------------------------------------------------
// sequence_detector
//
// Serial bit-pattern detector. One bit of x is sampled on every rising edge of
// clk. The FSM state is the length of the longest PATTERN prefix that is a
// suffix of the bits received so far (0 .. PAT_LEN-1). When the sampled bit
// completes the pattern, y is registered high for exactly one cycle.
//
// The transition table is built at elaboration time from PATTERN, so any
// pattern of legal length works without editing the logic.
//
// Parameters
//   PAT_LEN  pattern length in bits (2..16)
//   PATTERN  target sequence, MSB is the first bit received
//   OVERLAP  1: after a hit keep the longest proper border of PATTERN
//            0: after a hit restart from the empty match
//
// Ports
//   clk    in   rising-edge clock
//   reset  in   synchronous, active-high; clears the match state and y
//   x      in   serial data bit
//   y      out  registered one-cycle detect pulse
//
// Handshake: none. x is consumed unconditionally every cycle; y is a pure
// pulse with no back-pressure.
// -----------------------------------------------------------------------------
module sequence_detector #(
    parameter int unsigned        PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1101,
    parameter bit                 OVERLAP = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic x,
    output logic y
);

    // Enough bits to hold the largest live state, PAT_LEN-1.
    localparam int unsigned SW = $clog2(PAT_LEN);

    // States are numeric prefix lengths whose count depends on PAT_LEN, so
    // they are a plain vector type rather than a fixed enumeration. S_EMPTY
    // is the "nothing matched" state.
    typedef logic [SW-1:0] state_t;
    localparam state_t S_EMPTY = '0;

    // Bit i of the pattern in arrival order (i = 0 is the first bit received).
    function automatic logic pat_bit(input int i);
        logic [PAT_LEN-1:0] shifted;
        shifted = PATTERN >> (PAT_LEN - 1 - i);
        return shifted[0];
    endfunction

    // Length of the longest PATTERN prefix that is a suffix of the string
    // (first k pattern bits, then xb). This is exactly the value the KMP
    // failure links produce for the extended match; computing it directly is
    // simpler and costs nothing since it only runs at elaboration.
    // A result of PAT_LEN means the pattern has just been completed.
    function automatic int ext_len(input int k, input logic xb);
        int   best;
        int   j;
        logic ok;
        logic sb;
        best = 0;
        for (int l = 1; l <= k + 1; l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                j  = k + 1 - l + i;
                sb = (j == k) ? xb : pat_bit(j);
                if (pat_bit(i) != sb) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return best;
    endfunction

    // Longest proper prefix of PATTERN that is also a suffix of it: the state
    // an overlapping detector resumes from after a hit.
    function automatic int border_len();
        int   best;
        logic ok;
        best = 0;
        for (int l = 1; l < int'(PAT_LEN); l++) begin
            ok = 1'b1;
            for (int i = 0; i < l; i++) begin
                if (pat_bit(i) != pat_bit(int'(PAT_LEN) - l + i)) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return best;
    endfunction

    localparam int     BORDER    = border_len();
    localparam state_t HIT_STATE = OVERLAP ? state_t'(BORDER) : S_EMPTY;

    // Elaborated transition table, indexed [x][state].
    state_t nxt_tab [2][PAT_LEN];
    logic   hit_tab [2][PAT_LEN];

    for (genvar k = 0; k < int'(PAT_LEN); k++) begin : g_state
        for (genvar b = 0; b < 2; b++) begin : g_bit
            localparam int     LEN = ext_len(k, 1'(b));
            localparam logic   HIT = (LEN == int'(PAT_LEN));
            localparam state_t NXT = HIT ? HIT_STATE : state_t'(LEN);
            assign nxt_tab[b][k] = NXT;
            assign hit_tab[b][k] = HIT;
        end
    end

    state_t state;
    state_t state_nxt;
    logic   hit_nxt;

    // Next-state logic. Any state value outside 0..PAT_LEN-1 (unreachable,
    // only possible when PAT_LEN is not a power of two) falls back to empty.
    always_comb begin
        state_nxt = S_EMPTY;
        hit_nxt   = 1'b0;
        for (int k = 0; k < int'(PAT_LEN); k++) begin
            if (state == state_t'(k)) begin
                state_nxt = nxt_tab[x][k];
                hit_nxt   = hit_tab[x][k];
            end
        end
    end

    // State register. y is registered from the completing transition, so it
    // is stable for the whole cycle after the edge that sampled the last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_EMPTY;
            y     <= 1'b0;
        end else begin
            state <= state_nxt;
            y     <= hit_nxt;
        end
    end

endmodule

// File: tb/tb_sequence_detector.sv
// -----------------------------------------------------------------------------
// tb_sequence_detector
//
// Directed bench for sequence_detector. Three instances share clk/reset/x:
//   dut      PATTERN=1101, OVERLAP=1
//   dut_nov  PATTERN=1101, OVERLAP=0
//   dut_11   PATTERN=11,   OVERLAP=1 (back-to-back pulses)
// Inputs change 1 time unit after a rising edge; outputs are sampled 1 time
// unit after the following rising edge, i.e. the value held for the cycle
// that edge starts.
// -----------------------------------------------------------------------------
module tb_sequence_detector;

    logic clk;
    logic reset;
    logic x;
    logic y;
    logic y_nov;
    logic y_11;

    int tests_run    = 0;
    int tests_failed = 0;

    sequence_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y)
    );

    sequence_detector #(.PAT_LEN(4), .PATTERN(4'b1101), .OVERLAP(1'b0)) dut_nov (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y_nov)
    );

    sequence_detector #(.PAT_LEN(2), .PATTERN(2'b11), .OVERLAP(1'b1)) dut_11 (
        .clk   (clk),
        .reset (reset),
        .x     (x),
        .y     (y_11)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input logic [1:0] obs, input logic [1:0] exp, input string tag);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Reset held for n edges with x=1; after each edge y and state must be 0.
    task automatic do_reset(input int n, input string tag);
        reset = 1'b1;
        x     = 1'b1;
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            check({1'b0, y},     2'b00, $sformatf("%s r%0d y", tag, i));
            check({1'b0, y_nov}, 2'b00, $sformatf("%s r%0d y_nov", tag, i));
            check({1'b0, y_11},  2'b00, $sformatf("%s r%0d y_11", tag, i));
            check(dut.state,     2'b00, $sformatf("%s r%0d state", tag, i));
        end
        reset = 1'b0;
    endtask

    // Send one bit and check both 1101 detectors.
    task automatic send(input logic xb, input logic ey, input logic eyn, input string tag);
        x = xb;
        @(posedge clk);
        #1;
        check({1'b0, y},     {1'b0, ey},  {tag, " y"});
        check({1'b0, y_nov}, {1'b0, eyn}, {tag, " y_nov"});
    endtask

    // Send one bit and check all three detectors.
    task automatic send3(input logic xb, input logic ey, input logic eyn,
                         input logic e11, input string tag);
        send(xb, ey, eyn, tag);
        check({1'b0, y_11}, {1'b0, e11}, {tag, " y_11"});
    endtask

    // ---------------- directed sequence ----------------
    logic [31:0] stream;
    logic [3:0]  near_miss [4];
    logic [3:0]  nm;

    initial begin
        reset = 1'b1;
        x     = 1'b1;

        // 1. Reset for two edges with x=1.
        do_reset(2, "t1");

        // 2. 0,1,1,0,1 -> single pulse after edge 5.
        send(1'b0, 1'b0, 1'b0, "t2 e1");
        send(1'b1, 1'b0, 1'b0, "t2 e2");
        send(1'b1, 1'b0, 1'b0, "t2 e3");
        send(1'b0, 1'b0, 1'b0, "t2 e4");
        send(1'b1, 1'b1, 1'b1, "t2 e5");
        check(dut.state,     2'd1, "t2 state after hit (overlap)");
        check(dut_nov.state, 2'd0, "t2 state after hit (no overlap)");

        // 3. 1,1,0,1,1,0,1: overlap pulses after 4 and 7, no-overlap after 4.
        do_reset(1, "t3");
        send(1'b1, 1'b0, 1'b0, "t3 e1");
        send(1'b1, 1'b0, 1'b0, "t3 e2");
        send(1'b0, 1'b0, 1'b0, "t3 e3");
        send(1'b1, 1'b1, 1'b1, "t3 e4");
        send(1'b1, 1'b0, 1'b0, "t3 e5");
        send(1'b0, 1'b0, 1'b0, "t3 e6");
        send(1'b1, 1'b1, 1'b0, "t3 e7");

        // 4. 32-bit stream, pulses after edges 5, 12 and 19 only.
        do_reset(1, "t4");
        stream = 32'b0110_1001_1101_0001_1011_1100_0010_1110;
        for (int i = 1; i <= 32; i++) begin
            send(stream[32 - i],
                 (i == 5 || i == 12 || i == 19),
                 (i == 5 || i == 12 || i == 19),
                 $sformatf("t4 e%0d", i));
        end

        // 5. Reset in the middle of 1,1,0 discards the partial match.
        do_reset(1, "t5a");
        send(1'b1, 1'b0, 1'b0, "t5 e1");
        send(1'b1, 1'b0, 1'b0, "t5 e2");
        send(1'b0, 1'b0, 1'b0, "t5 e3");
        do_reset(1, "t5b");
        send(1'b1, 1'b0, 1'b0, "t5 e4");
        send(1'b1, 1'b0, 1'b0, "t5 e5");
        send(1'b1, 1'b0, 1'b0, "t5 e6");
        send(1'b0, 1'b0, 1'b0, "t5 e7");
        send(1'b1, 1'b1, 1'b1, "t5 e8");

        // 6. Near-misses never pulse.
        near_miss[0] = 4'b1111;
        near_miss[1] = 4'b1100;
        near_miss[2] = 4'b0101;
        near_miss[3] = 4'b1001;
        for (int p = 0; p < 4; p++) begin
            do_reset(1, $sformatf("t6 p%0d", p));
            nm = near_miss[p];
            for (int i = 3; i >= 0; i--) begin
                send(nm[i], 1'b0, 1'b0, $sformatf("t6 p%0d b%0d", p, 3 - i));
            end
        end

        // 7. PATTERN=11 with overlap pulses on consecutive cycles;
        //    1101 detectors see 1,1,1,0,1 -> hit on edge 5.
        do_reset(1, "t7");
        send3(1'b1, 1'b0, 1'b0, 1'b0, "t7 e1");
        send3(1'b1, 1'b0, 1'b0, 1'b1, "t7 e2");
        send3(1'b1, 1'b0, 1'b0, 1'b1, "t7 e3");
        send3(1'b0, 1'b0, 1'b0, 1'b0, "t7 e4");
        send3(1'b1, 1'b1, 1'b1, 1'b0, "t7 e5");
        send3(1'b1, 1'b0, 1'b0, 1'b1, "t7 e6");

        // ---------------- report ----------------
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
